ludh_inst_sequencer: RTL and testbench
======================================

Name: ludh_inst_sequencer

Overview:
- Parametrised instruction store and issue engine. It holds CTRL_WIDTH-wide control words in an internal memory and issues them one at a time to the LU datapath as ctrl_signal.
- Host loads and reads the memory 32 bits at a time through a staging register. Word width and part count are parametric.
- New over the previous tester: programmable instruction count, loop repeat, stall back-pressure, single-step debug, and a valid strobe with zeroed idle control.

Parameters:
- ADDR_WIDTH, 12, instruction memory address width; depth = 2**ADDR_WIDTH.
- CTRL_WIDTH, 307, control word width.
- PART_WIDTH, 32, host bus width.
- NUM_PARTS, (CTRL_WIDTH+PART_WIDTH-1)/PART_WIDTH (=10), derived localparam; host parts per word.
- PSEL_WIDTH, 4, part-select width; must satisfy 2**PSEL_WIDTH >= NUM_PARTS.
- LOOP_WIDTH, 8, repeat counter width.

Ports:
- CLK_100  in  1  sole clock.
- RST_IN  in  1  asynchronous, active-high reset.
- host_addr  in  ADDR_WIDTH  word address for host commit and read.
- host_part_sel  in  PSEL_WIDTH  part index k, selecting bits [PART_WIDTH*k+PART_WIDTH-1 : PART_WIDTH*k].
- host_din  in  PART_WIDTH  staging write data.
- host_we  in  1  writes host_din into staging part host_part_sel.
- host_commit  in  1  writes the full staging word to mem[host_addr].
- host_en  in  1  read enable.
- host_dout  out  PART_WIDTH  read data, 1-cycle latency.
- START  in  1  run request; acted on at its rising edge.
- inst_count  in  ADDR_WIDTH+1  instructions per pass; 0 means no run.
- loop_count  in  LOOP_WIDTH  passes; 0 is treated as 1.
- step_mode  in  1  when 1, each issue waits for step.
- step  in  1  single-cycle advance pulse.
- stall  in  1  datapath back-pressure.
- ctrl_signal  out  CTRL_WIDTH  issued control word.
- ctrl_valid  out  1  ctrl_signal is a live instruction this cycle.
- pc  out  ADDR_WIDTH  address of the current or next instruction.
- busy  out  1  high in FETCH and ISSUE.
- COMPLETED  out  1  run finished.
- debug_state  out  2  FSM encoding.

Behaviour:
- Reset (async, RST_IN=1), all outputs 0: ctrl_signal, ctrl_valid, COMPLETED, busy, host_dout, pc, debug_state=IDLE. Internal loop and edge registers also clear. Memory and staging contents are not cleared.
- Reset mid-run: returns to IDLE immediately; no further ctrl_valid.
- Memory: synchronous read, one port shared between host and engine.
  - host_commit is honoured only in IDLE or DONE; ignored when busy.
  - host_we to staging is always honoured.
- Host read: with host_en=1, host_dout is registered part host_part_sel of mem[host_addr] on the next cycle.
  - The top part is zero-padded above CTRL_WIDTH.
  - host_part_sel >= NUM_PARTS returns 0.
  - While busy, host_dout returns 0.
- START edge: START=1 with the previous-cycle START=0.
- FSM states: IDLE=0, FETCH=1, ISSUE=2, DONE=3.
- IDLE:
  - START edge with inst_count!=0 → FETCH. Latch inst_count and loop_count (0→1), set pc=0.
  - START edge with inst_count=0 → DONE directly.
- FETCH: present read address pc for one cycle → ISSUE.
- ISSUE: advance condition = !stall && (!step_mode || step).
  - If not met, stay in ISSUE; ctrl_valid=0, pc held.
  - If met, the next cycle has ctrl_signal = mem[pc] and ctrl_valid=1 for exactly that one cycle.
  - If pc < count-1: pc+1 → FETCH.
  - Else if loops_left>1: loops_left-1, pc=0 → FETCH.
  - Else → DONE.
- Throughput: one instruction per 2 cycles with no stall.
- Latency: START edge to first ctrl_valid = 3 cycles.
- ctrl_signal is all-zero whenever ctrl_valid=0 (NOP-safe).
- DONE: COMPLETED=1, held. Return to IDLE when START=0, so COMPLETED falls one cycle after START falls. A new run requires a fresh START edge.
- Simultaneous events:
  - host_commit in the same cycle as the START edge: the write lands first, and FETCH sees the new data.
  - stall and step together: stall wins and the step pulse is lost.
  - START held high after DONE does not restart a run.
- Width rules: pc never wraps. inst_count=2**ADDR_WIDTH is legal and issues the full memory, last pc = depth-1.

Test Plan:
- Load/readback: stage 10 parts 0x1000_0000+k, commit to address 5, read parts 0..9 → part k = 0x1000_0000+k. Part 9 masked to its low 19 bits; part_sel 12 → 0.
- Basic run: load words 0..3, inst_count=4, loop_count=0, START pulse → ctrl_valid on cycles 3,5,7,9 with words 0..3 in order. ctrl_signal=0 between issues. COMPLETED high after the last issue.
- Loop: inst_count=2, loop_count=3 → 6 issues in order w0,w1,w0,w1,w0,w1, then DONE. debug_state goes 0→1→2…→3.
- Stall: assert stall for 5 cycles during the 2nd ISSUE → no ctrl_valid during stall, pc holds 1, word 1 issues the cycle after stall drops. Total count unchanged.
- Step mode: step_mode=1, pulse step 3 times → exactly 3 issues. A step coincident with stall produces no issue.
- Reset/edge cases: RST_IN mid-run → all outputs 0 asynchronously, IDLE. inst_count=0 START → COMPLETED with no ctrl_valid. host_commit while busy leaves memory unchanged.

Source files
------------

// File: rtl/ludh_inst_sequencer.sv
// Instruction store and issue engine: host loads control words through a
// part-wise staging register, the engine issues them to the LU datapath.
module ludh_inst_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int CTRL_WIDTH = 307,
    parameter int PART_WIDTH = 32,
    parameter int PSEL_WIDTH = 4,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  CLK_100,
    input  logic                  RST_IN,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [PSEL_WIDTH-1:0] host_part_sel,
    input  logic [PART_WIDTH-1:0] host_din,
    input  logic                  host_we,
    input  logic                  host_commit,
    input  logic                  host_en,
    output logic [PART_WIDTH-1:0] host_dout,
    input  logic                  START,
    input  logic [ADDR_WIDTH:0]   inst_count,
    input  logic [LOOP_WIDTH-1:0] loop_count,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  stall,
    output logic [CTRL_WIDTH-1:0] ctrl_signal,
    output logic                  ctrl_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  COMPLETED,
    output logic [1:0]            debug_state
);

    localparam int NUM_PARTS = (CTRL_WIDTH + PART_WIDTH - 1) / PART_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [CTRL_WIDTH-1:0] mem [DEPTH];
    logic [PART_WIDTH-1:0] staging [NUM_PARTS];
    logic [PART_WIDTH-1:0] rd_parts [NUM_PARTS];
    logic [CTRL_WIDTH-1:0] commit_word;
    logic [CTRL_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [LOOP_WIDTH-1:0] loops_left;
    logic [PSEL_WIDTH-1:0] psel_q;
    logic                  start_q;
    logic                  host_rd_q;
    logic                  psel_ok;
    logic                  advance;
    logic                  last_in_pass;

    // Top part is narrower than PART_WIDTH; it is truncated on commit and
    // zero-padded on readback.
    for (genvar k = 0; k < NUM_PARTS; k++) begin : g_part
        localparam int LO = k * PART_WIDTH;
        localparam int W  = (CTRL_WIDTH - LO < PART_WIDTH) ? CTRL_WIDTH - LO : PART_WIDTH;
        assign commit_word[LO +: W] = staging[k][W-1:0];
        assign rd_parts[k]          = PART_WIDTH'(rd_q[LO +: W]);
    end

    assign psel_ok      = {1'b0, host_part_sel} < (PSEL_WIDTH + 1)'(NUM_PARTS);
    assign busy         = (state == FETCH) || (state == ISSUE);
    assign COMPLETED    = (state == DONE);
    assign debug_state  = state;
    assign rd_addr      = busy ? pc : host_addr;
    assign advance      = !stall && (!step_mode || step);
    assign last_in_pass = (pc == '1) || (({1'b0, pc} + (ADDR_WIDTH + 1)'(1)) >= count_q);
    assign host_dout    = host_rd_q ? rd_parts[psel_q] : '0;

    // Single shared port: the engine owns the address while busy.
    always_ff @(posedge CLK_100) begin
        if (host_we && psel_ok) begin
            staging[host_part_sel] <= host_din;
        end
        if (host_commit && !busy) begin
            mem[host_addr] <= commit_word;
        end
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge CLK_100 or posedge RST_IN) begin
        if (RST_IN) begin
            state       <= IDLE;
            pc          <= '0;
            count_q     <= '0;
            loops_left  <= '0;
            start_q     <= 1'b0;
            ctrl_signal <= '0;
            ctrl_valid  <= 1'b0;
            host_rd_q   <= 1'b0;
            psel_q      <= '0;
        end else begin
            start_q     <= START;
            ctrl_signal <= '0;
            ctrl_valid  <= 1'b0;
            host_rd_q   <= host_en && !busy && psel_ok;
            psel_q      <= host_part_sel;
            case (state)
                IDLE: begin
                    if (START && !start_q) begin
                        if (inst_count != '0) begin
                            state      <= FETCH;
                            count_q    <= inst_count;
                            loops_left <= (loop_count == '0) ? LOOP_WIDTH'(1) : loop_count;
                            pc         <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: state <= ISSUE;
                ISSUE: begin
                    if (advance) begin
                        ctrl_signal <= rd_q;
                        ctrl_valid  <= 1'b1;
                        if (!last_in_pass) begin
                            pc    <= pc + ADDR_WIDTH'(1);
                            state <= FETCH;
                        end else if (loops_left > LOOP_WIDTH'(1)) begin
                            loops_left <= loops_left - LOOP_WIDTH'(1);
                            pc         <= '0;
                            state      <= FETCH;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!START) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ludh_inst_sequencer.sv
// Directed bench for ludh_inst_sequencer: load/readback, run timing, loops,
// stall, single-step, reset and edge cases.
module tb_ludh_inst_sequencer;

    localparam int AW = 12;
    localparam int CW = 307;
    localparam int PW = 32;
    localparam int NP = 10;
    localparam int PSW = 4;
    localparam int LW = 8;

    logic          CLK_100 = 1'b0;
    logic          RST_IN;
    logic [AW-1:0] host_addr;
    logic [PSW-1:0] host_part_sel;
    logic [PW-1:0] host_din;
    logic          host_we;
    logic          host_commit;
    logic          host_en;
    logic [PW-1:0] host_dout;
    logic          START;
    logic [AW:0]   inst_count;
    logic [LW-1:0] loop_count;
    logic          step_mode;
    logic          step;
    logic          stall;
    logic [CW-1:0] ctrl_signal;
    logic          ctrl_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          COMPLETED;
    logic [1:0]    debug_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK_100 = ~CLK_100;

    ludh_inst_sequencer #(
        .ADDR_WIDTH (AW),
        .CTRL_WIDTH (CW),
        .PART_WIDTH (PW),
        .PSEL_WIDTH (PSW),
        .LOOP_WIDTH (LW)
    ) dut (
        .CLK_100       (CLK_100),
        .RST_IN        (RST_IN),
        .host_addr     (host_addr),
        .host_part_sel (host_part_sel),
        .host_din      (host_din),
        .host_we       (host_we),
        .host_commit   (host_commit),
        .host_en       (host_en),
        .host_dout     (host_dout),
        .START         (START),
        .inst_count    (inst_count),
        .loop_count    (loop_count),
        .step_mode     (step_mode),
        .step          (step),
        .stall         (stall),
        .ctrl_signal   (ctrl_signal),
        .ctrl_valid    (ctrl_valid),
        .pc            (pc),
        .busy          (busy),
        .COMPLETED     (COMPLETED),
        .debug_state   (debug_state)
    );

    task automatic check(input string tag, input logic [CW:0] obs, input logic [CW:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] wgen(input int unsigned i);
        logic [NP*PW-1:0] f;
        for (int k = 0; k < NP; k++) f[k*PW +: PW] = 32'hA500_0000 + (i << 8) + k;
        return f[CW-1:0];
    endfunction

    function automatic logic [PW-1:0] part_of(input logic [CW-1:0] w, input int k);
        logic [NP*PW-1:0] f;
        f = '0;
        f[CW-1:0] = w;
        return f[k*PW +: PW];
    endfunction

    task automatic stage_word(input logic [CW-1:0] w);
        for (int k = 0; k < NP; k++) begin
            host_we = 1'b1;
            host_part_sel = PSW'(k);
            host_din = part_of(w, k);
            @(negedge CLK_100);
        end
        host_we = 1'b0;
    endtask

    task automatic load(input int a, input logic [CW-1:0] w);
        stage_word(w);
        host_addr = AW'(a);
        host_commit = 1'b1;
        @(negedge CLK_100);
        host_commit = 1'b0;
    endtask

    task automatic read_part(input int a, input int k, output logic [PW-1:0] d);
        host_en = 1'b1;
        host_addr = AW'(a);
        host_part_sel = PSW'(k);
        @(negedge CLK_100);
        d = host_dout;
        host_en = 1'b0;
    endtask

    // Returns at the negedge of cycle 1 (the FETCH cycle).
    task automatic start_run(input int ic, input int lc);
        inst_count = (AW+1)'(ic);
        loop_count = LW'(lc);
        START = 1'b1;
        @(negedge CLK_100);
        START = 1'b0;
    endtask

    function automatic logic [CW:0] issue_word(input int idx);
        return (idx < 0) ? '0 : {1'b1, wgen(idx)};
    endfunction

    initial begin
        logic [PW-1:0] d;
        int idx;
        int n;

        RST_IN = 1'b1;
        host_addr = '0; host_part_sel = '0; host_din = '0;
        host_we = 1'b0; host_commit = 1'b0; host_en = 1'b0;
        START = 1'b0; inst_count = '0; loop_count = '0;
        step_mode = 1'b0; step = 1'b0; stall = 1'b0;
        @(negedge CLK_100);
        @(negedge CLK_100);
        check("rst_ctrl", {ctrl_valid, ctrl_signal}, '0);
        check("rst_status", (CW+1)'({pc, busy, COMPLETED, debug_state, host_dout}), '0);
        RST_IN = 1'b0;
        @(negedge CLK_100);

        // Load/readback
        for (int k = 0; k < NP; k++) begin
            host_we = 1'b1; host_part_sel = PSW'(k); host_din = 32'h1000_0000 + k;
            @(negedge CLK_100);
        end
        host_we = 1'b0;
        host_addr = AW'(5); host_commit = 1'b1;
        @(negedge CLK_100);
        host_commit = 1'b0;
        for (int k = 0; k < NP; k++) begin
            read_part(5, k, d);
            check($sformatf("rd_part%0d", k), (CW+1)'(d),
                  (CW+1)'((k == 9) ? 32'h0000_0009 : 32'h1000_0000 + k));
        end
        read_part(5, 12, d);
        check("rd_part12", (CW+1)'(d), '0);

        // Basic run
        for (int i = 0; i < 4; i++) load(i, wgen(i));
        start_run(4, 0);
        for (int c = 1; c <= 10; c++) begin
            idx = (c == 3) ? 0 : (c == 5) ? 1 : (c == 7) ? 2 : (c == 9) ? 3 : -1;
            check($sformatf("basic_c%0d", c), {ctrl_valid, ctrl_signal}, issue_word(idx));
            if (c == 1) check("basic_fetch", (CW+1)'(debug_state), (CW+1)'(1));
            if (c == 2) check("basic_issue", (CW+1)'(debug_state), (CW+1)'(2));
            if (c == 4) check("basic_pc", (CW+1)'(pc), (CW+1)'(1));
            if (c == 9) check("basic_done", (CW+1)'({COMPLETED, debug_state}), (CW+1)'(3'b111));
            if (c == 10) check("basic_idle", (CW+1)'({COMPLETED, debug_state}), '0);
            if (c < 10) @(negedge CLK_100);
        end

        // Loop repeat
        start_run(2, 3);
        for (int c = 1; c <= 14; c++) begin
            idx = (c >= 3 && c <= 13 && (c % 2) == 1) ? ((c - 3) / 2) % 2 : -1;
            check($sformatf("loop_c%0d", c), {ctrl_valid, ctrl_signal}, issue_word(idx));
            if (c == 13) check("loop_done", (CW+1)'({COMPLETED, debug_state}), (CW+1)'(3'b111));
            if (c < 14) @(negedge CLK_100);
        end

        // Stall during second ISSUE
        start_run(4, 1);
        for (int c = 1; c <= 15; c++) begin
            idx = (c == 3) ? 0 : (c == 10) ? 1 : (c == 12) ? 2 : (c == 14) ? 3 : -1;
            check($sformatf("stall_c%0d", c), {ctrl_valid, ctrl_signal}, issue_word(idx));
            if (c >= 4 && c <= 9) check($sformatf("stall_pc_c%0d", c), (CW+1)'(pc), (CW+1)'(1));
            if (c == 14) check("stall_done", (CW+1)'(COMPLETED), (CW+1)'(1));
            stall = (c >= 4 && c <= 8);
            if (c < 15) @(negedge CLK_100);
        end
        stall = 1'b0;

        // Single-step, including a step lost to stall
        step_mode = 1'b1;
        n = 0;
        start_run(3, 1);
        for (int c = 1; c <= 15; c++) begin
            idx = (c == 5) ? 0 : (c == 10) ? 1 : (c == 14) ? 2 : -1;
            check($sformatf("step_c%0d", c), {ctrl_valid, ctrl_signal}, issue_word(idx));
            if (ctrl_valid) n++;
            if (c == 8) check("step_stalled", (CW+1)'({pc, debug_state}), (CW+1)'({AW'(1), 2'd2}));
            step = (c == 4 || c == 7 || c == 9 || c == 13);
            stall = (c == 7);
            if (c < 15) @(negedge CLK_100);
        end
        step = 1'b0; stall = 1'b0; step_mode = 1'b0;
        check("step_count", (CW+1)'(n), (CW+1)'(3));

        // Asynchronous reset mid-run
        start_run(4, 1);
        @(negedge CLK_100);
        @(negedge CLK_100);
        check("rstrun_live", (CW+1)'(ctrl_valid), (CW+1)'(1));
        #1 RST_IN = 1'b1;
        #1;
        check("rstrun_ctrl", {ctrl_valid, ctrl_signal}, '0);
        check("rstrun_status", (CW+1)'({pc, busy, COMPLETED, debug_state, host_dout}), '0);
        @(negedge CLK_100);
        RST_IN = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK_100);
            if (ctrl_valid || debug_state != 2'd0) n++;
        end
        check("rstrun_quiet", (CW+1)'(n), '0);

        // inst_count = 0, START held high in DONE
        inst_count = '0; loop_count = '0; START = 1'b1;
        n = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK_100);
            if (ctrl_valid || !COMPLETED || debug_state != 2'd3) n++;
        end
        check("zero_done_held", (CW+1)'(n), '0);
        START = 1'b0;
        @(negedge CLK_100);
        check("zero_release", (CW+1)'({COMPLETED, debug_state}), '0);

        // Host access while busy
        stage_word(wgen(99));
        start_run(4, 1);
        host_en = 1'b1; host_addr = AW'(5); host_part_sel = '0;
        @(negedge CLK_100);
        host_en = 1'b0;
        check("busy_read", (CW+1)'(host_dout), '0);
        host_commit = 1'b1; host_addr = AW'(2);
        @(negedge CLK_100);
        host_commit = 1'b0;
        for (int c = 3; c <= 9; c++) begin
            idx = (c == 3) ? 0 : (c == 5) ? 1 : (c == 7) ? 2 : (c == 9) ? 3 : -1;
            check($sformatf("busy_run_c%0d", c), {ctrl_valid, ctrl_signal}, issue_word(idx));
            @(negedge CLK_100);
        end
        read_part(2, 0, d);
        check("busy_commit_p0", (CW+1)'(d), (CW+1)'(part_of(wgen(2), 0)));
        read_part(2, 9, d);
        check("busy_commit_p9", (CW+1)'(d), (CW+1)'(part_of(wgen(2), 9)));

        // Commit coincident with START edge: FETCH must see the new word
        inst_count = (AW+1)'(1); loop_count = LW'(1);
        host_addr = '0; host_commit = 1'b1; START = 1'b1;
        @(negedge CLK_100);
        host_commit = 1'b0; START = 1'b0;
        @(negedge CLK_100);
        @(negedge CLK_100);
        check("commit_start", {ctrl_valid, ctrl_signal}, {1'b1, wgen(99)});
        @(negedge CLK_100);

        // Full-depth run: 4096 issues, last pc = 4095
        start_run(4096, 1);
        n = 0;
        for (int c = 1; c <= 8400; c++) begin
            if (ctrl_valid) n++;
            if (COMPLETED) break;
            @(negedge CLK_100);
        end
        check("full_done", (CW+1)'(COMPLETED), (CW+1)'(1));
        check("full_count", (CW+1)'(n), (CW+1)'(4096));
        check("full_last_pc", (CW+1)'(pc), (CW+1)'(4095));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
